// File: rtl/segre_history_file_if.sv
// Decode/writeback-facing bundle of the history file: allocation, completion, retirement and recovery.
// The history file itself connects to the slave side; decode/writeback logic (or a bench) takes the master side.
interface segre_history_file_if #(
    parameter int HF_SIZE   = 8,
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5
);
    localparam int HF_PTR = $clog2(HF_SIZE);

    logic                 alloc_valid_i;
    logic [HF_PTR-1:0]    alloc_id_i;
    logic                 alloc_rf_we_i;
    logic [REG_SIZE-1:0]  alloc_rd_i;
    logic [WORD_SIZE-1:0] alloc_old_data_i;
    logic                 alloc_store_i;
    logic [WORD_SIZE-1:0] alloc_pc_i;

    logic                 complete_valid_i;
    logic [HF_PTR-1:0]    complete_id_i;
    logic                 complete_exc_i;

    logic                 full_o;
    logic                 empty_o;
    logic                 retire_valid_o;
    logic [HF_PTR-1:0]    retire_id_o;
    logic                 store_commit_o;
    logic                 recover_we_o;
    logic [REG_SIZE-1:0]  recover_rd_o;
    logic [WORD_SIZE-1:0] recover_data_o;
    logic                 flush_o;
    logic                 exc_o;
    logic [WORD_SIZE-1:0] exc_pc_o;
    logic [HF_PTR-1:0]    resync_id_o;

    modport slave (
        input  alloc_valid_i, alloc_id_i, alloc_rf_we_i, alloc_rd_i,
               alloc_old_data_i, alloc_store_i, alloc_pc_i,
               complete_valid_i, complete_id_i, complete_exc_i,
        output full_o, empty_o, retire_valid_o, retire_id_o, store_commit_o,
               recover_we_o, recover_rd_o, recover_data_o,
               flush_o, exc_o, exc_pc_o, resync_id_o
    );

    modport master (
        output alloc_valid_i, alloc_id_i, alloc_rf_we_i, alloc_rd_i,
               alloc_old_data_i, alloc_store_i, alloc_pc_i,
               complete_valid_i, complete_id_i, complete_exc_i,
        input  full_o, empty_o, retire_valid_o, retire_id_o, store_commit_o,
               recover_we_o, recover_rd_o, recover_data_o,
               flush_o, exc_o, exc_pc_o, resync_id_o
    );
endinterface

// File: rtl/segre_history_file.sv
// In-order history file: records old rd values, retires in order, walks back youngest-first on exception.
// Retire one cycle after head completes; full_o stalls decode while count is max or rollback runs.
module segre_history_file #(
    parameter int HF_SIZE   = 8,
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int HF_PTR    = $clog2(HF_SIZE)
) (
    input logic                 clk_i,
    input logic                 rsn_i,
    segre_history_file_if.slave hf
);
    localparam logic [0:0]      ST_RUN      = 1'b0;
    localparam logic [0:0]      ST_ROLLBACK = 1'b1;
    localparam logic [HF_PTR:0] FULL_COUNT  = (HF_PTR+1)'(HF_SIZE);

    logic [0:0]           r_state;
    logic [HF_PTR-1:0]    r_head;
    logic [HF_PTR-1:0]    r_tail;
    logic [HF_PTR-1:0]    r_rb_ptr;
    logic [HF_PTR:0]      r_count;
    logic [HF_SIZE-1:0]   r_valid;
    logic [HF_SIZE-1:0]   r_done;
    logic [HF_SIZE-1:0]   r_exc;
    logic [WORD_SIZE-1:0] r_exc_pc;

    logic [HF_SIZE-1:0]   r_rf_we;
    logic [HF_SIZE-1:0]   r_store;
    logic [REG_SIZE-1:0]  r_rd       [HF_SIZE];
    logic [WORD_SIZE-1:0] r_old_data [HF_SIZE];
    logic [WORD_SIZE-1:0] r_pc       [HF_SIZE];

    logic w_run;
    logic w_rb;
    logic w_full;
    logic w_alloc;
    logic w_complete;
    logic w_head_ready;
    logic w_retire;
    logic w_take_exc;
    logic w_rb_last;

    assign w_run        = (r_state == ST_RUN);
    assign w_rb         = (r_state == ST_ROLLBACK);
    assign w_full       = (r_count == FULL_COUNT) || w_rb;
    assign w_alloc      = hf.alloc_valid_i && !w_full;
    assign w_complete   = hf.complete_valid_i && w_run && r_valid[hf.complete_id_i];
    assign w_head_ready = w_run && r_valid[r_head] && r_done[r_head];
    assign w_retire     = w_head_ready && !r_exc[r_head];
    assign w_take_exc   = w_head_ready && r_exc[r_head];
    assign w_rb_last    = w_rb && (r_rb_ptr == r_head);

    assign hf.full_o         = w_full;
    assign hf.empty_o        = (r_count == '0);
    assign hf.retire_valid_o = w_retire;
    assign hf.retire_id_o    = w_retire ? r_head : '0;
    assign hf.store_commit_o = w_retire && r_store[r_head];
    // Stores carry rf_we=0, so they fall out of the restore stream naturally.
    assign hf.recover_we_o   = w_rb && r_rf_we[r_rb_ptr];
    assign hf.recover_rd_o   = w_rb ? r_rd[r_rb_ptr] : '0;
    assign hf.recover_data_o = w_rb ? r_old_data[r_rb_ptr] : '0;
    assign hf.flush_o        = w_rb;
    assign hf.exc_o          = w_rb_last;
    assign hf.exc_pc_o       = w_rb_last ? r_exc_pc : '0;
    assign hf.resync_id_o    = w_rb_last ? r_head : '0;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state  <= ST_RUN;
            r_head   <= '0;
            r_tail   <= '0;
            r_rb_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_done   <= '0;
            r_exc    <= '0;
            r_exc_pc <= '0;
        end else if (w_run) begin
            if (w_complete) begin
                r_done[hf.complete_id_i] <= 1'b1;
                r_exc[hf.complete_id_i]  <= hf.complete_exc_i;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_take_exc) begin
                r_exc_pc <= r_pc[r_head];
                r_rb_ptr <= r_tail - 1'b1;
                r_state  <= ST_ROLLBACK;
            end
            // Decode owns the numbering: write where it says, and follow its id for tail.
            if (w_alloc) begin
                r_valid[hf.alloc_id_i] <= 1'b1;
                r_done[hf.alloc_id_i]  <= 1'b0;
                r_exc[hf.alloc_id_i]   <= 1'b0;
                r_tail                 <= hf.alloc_id_i + 1'b1;
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end else begin
            r_valid[r_rb_ptr] <= 1'b0;
            r_rb_ptr          <= r_rb_ptr - 1'b1;
            if (w_rb_last) begin
                r_valid <= '0;
                r_tail  <= r_head;
                r_count <= '0;
                r_state <= ST_RUN;
            end
        end
    end

    // Payload is qualified by r_valid everywhere, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_rf_we[hf.alloc_id_i]    <= hf.alloc_rf_we_i;
            r_store[hf.alloc_id_i]    <= hf.alloc_store_i;
            r_rd[hf.alloc_id_i]       <= hf.alloc_rd_i;
            r_old_data[hf.alloc_id_i] <= hf.alloc_old_data_i;
            r_pc[hf.alloc_id_i]       <= hf.alloc_pc_i;
        end
    end
endmodule
